// File: rtl/dpcm_pkg.sv
// Shared types and helpers for the DPCM arbiter family.
// Optional burst mode of dpcm_arbiter is enabled by defining DPCM_ARB_BURST_EN.
package dpcm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } dpcm_arb_state_t;

  localparam int DPCM_DW_DEF = 32;
  // Widest sample the shared helper supports; callers zero-extend into it.
  localparam int DPCM_DW_MAX = 64;

  function automatic logic [DPCM_DW_MAX-1:0] abs_diff(
    input logic [DPCM_DW_MAX-1:0] a,
    input logic [DPCM_DW_MAX-1:0] b
  );
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/dpcm_rr_arb.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
// Zero latency; no state, so backpressure is the caller's concern.
module dpcm_rr_arb #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int i = 0; i < N; i++) begin
      j = IW'((int'(ptr) + i) % N);
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/dpcm_arbiter.sv
// Shares one |x[n]-x[n-1]| engine across N_CH channels; result 2 cycles after grant,
// held until out_ready. Define DPCM_ARB_BURST_EN to allow up to BURST back-to-back grants.
module dpcm_arbiter
  import dpcm_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int DW    = DPCM_DW_DEF,
  parameter int BURST = 4,
  parameter int CW    = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          req_valid,
  input  logic [N_CH-1:0][DW-1:0]  req_data,
  output logic [N_CH-1:0]          req_ready,
  input  logic [N_CH-1:0]          ctx_clr,
  output logic                     out_valid,
  output logic [DW-1:0]            out_data,
  output logic [CW-1:0]            out_ch,
  input  logic                     out_ready
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_OUT  = OUT;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] out_data_q;
  logic [CW-1:0] out_ch_q;
  logic [DW-1:0] hist_q [N_CH];

  logic [CW-1:0]   arb_ptr;
  logic [N_CH-1:0] gnt;
  logic [CW-1:0]   win;
  logic            any;
  logic            hs;

  dpcm_rr_arb #(.N(N_CH), .IW(CW)) u_rr (
    .req (req_valid),
    .ptr (arb_ptr),
    .gnt (gnt),
    .idx (win),
    .any (any)
  );

  assign hs = (state_q == S_IDLE) && any;

`ifdef DPCM_ARB_BURST_EN
  localparam int BW = $clog2(BURST + 1);
  logic [BW-1:0] burst_q, burst_d;
  logic          burst_ok;

  // Searching from the last channel re-grants it if still valid; otherwise rotation resumes.
  assign burst_ok = (int'(burst_q) < BURST);
  assign arb_ptr  = burst_ok ? ch_q : ptr_q;

  always_comb begin
    burst_d = burst_q;
    if (hs) burst_d = (burst_ok && (win == ch_q)) ? burst_q + 1'b1 : BW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) burst_q <= '0;
    else     burst_q <= burst_d;
  end
`else
  logic unused_burst;
  assign unused_burst = ^BURST;
  assign arb_ptr      = ptr_q;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ch_d    = ch_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: if (any) begin
        data_d  = req_data[win];
        ch_d    = win;
        ptr_d   = (int'(win) == N_CH - 1) ? '0 : win + 1'b1;
        state_d = S_CALC;
      end
      S_CALC:  state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      ch_q       <= '0;
      data_q     <= '0;
      out_data_q <= '0;
      out_ch_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      if (state_q == S_CALC) begin
        out_data_q <= DW'(abs_diff(DPCM_DW_MAX'(data_q), DPCM_DW_MAX'(hist_q[ch_q])));
        out_ch_q   <= ch_q;
      end
    end
  end

  // A clear wins over the same-cycle history update; the result already used the old value.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (rst || ctx_clr[i])
        hist_q[i] <= '0;
      else if ((state_q == S_CALC) && (ch_q == CW'(i)))
        hist_q[i] <= data_q;
    end
  end

  assign req_ready = (state_q == S_IDLE) ? gnt : '0;
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_dpcm_arbiter.sv
// Directed bench for dpcm_arbiter: drives and samples on the falling edge.
module tb_dpcm_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req_valid;
  logic [3:0][31:0] req_data;
  logic [3:0]       req_ready;
  logic [3:0]       ctx_clr;
  logic             out_valid;
  logic [31:0]      out_data;
  logic [1:0]       out_ch;
  logic             out_ready;

  int checks = 0;
  int errors = 0;

  int t2_ch [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int t2_d  [8] = '{10, 20, 30, 40, 0, 0, 0, 0};
`ifdef DPCM_ARB_BURST_EN
  int t6_ch [6] = '{0, 0, 1, 1, 0, 0};
  int t6_d  [6] = '{5, 0, 6, 0, 0, 0};
`else
  int t6_ch [6] = '{0, 1, 0, 1, 0, 1};
  int t6_d  [6] = '{5, 6, 0, 0, 0, 0};
`endif

  dpcm_arbiter #(.N_CH(4), .DW(32), .BURST(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .ctx_clr   (ctx_clr),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, out_valid, 1);
  endtask

  // One transaction with latency checks; optionally pulses ctx_clr[ch] in the CALC cycle.
  task automatic txn(input string tag, input logic [1:0] ch, input logic [31:0] d,
                     input logic [31:0] exp, input bit clr_calc);
    int n = 0;
    req_data[ch]  = d;
    req_valid[ch] = 1'b1;
    #1;
    while (!req_ready[ch] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_grant"}, req_ready[ch], 1);
    chk({tag, "_vld_t0"}, out_valid, 0);
    @(negedge clk);
    req_valid[ch] = 1'b0;
    chk({tag, "_vld_t1"}, out_valid, 0);
    if (clr_calc) ctx_clr[ch] = 1'b1;
    @(negedge clk);
    ctx_clr = '0;
    chk({tag, "_vld_t2"}, out_valid, 1);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_ch"}, out_ch, ch);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    ctx_clr   = '0;
    out_ready = 1'b1;
    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_vld", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_rdy", req_ready, 0);

    // 1: first sample returns itself, second the difference
    txn("t1a", 2'd0, 32'd100, 32'd100, 1'b0);
    txn("t1b", 2'd0, 32'd40, 32'd60, 1'b0);

    // 2: all channels continuously valid
    do_reset();
    for (int i = 0; i < 4; i++) req_data[i] = 32'(10 * (i + 1));
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      wait_out("t2_wait");
      chk("t2_ch", out_ch, t2_ch[k]);
      chk("t2_data", out_data, t2_d[k]);
      if (k == 7) req_valid = '0;
      @(negedge clk);
    end

    // 3: downstream stall; ch3 hist=40, ptr=0
    out_ready    = 1'b0;
    req_data[3]  = 32'd99;
    req_valid    = 4'b1000;
    wait_out("t3_wait");
    req_valid    = 4'b0001;
    req_data[0]  = 32'd15;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_vld", out_valid, 1);
      chk("t3_data", out_data, 59);
      chk("t3_ch", out_ch, 3);
      chk("t3_rdy", req_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_resume_rdy", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("t3_resume_vld", out_valid, 1);
    chk("t3_resume_data", out_data, 5);
    chk("t3_resume_ch", out_ch, 0);
    @(negedge clk);

    // 4: clear during CALC beats the history write
    ctx_clr[2] = 1'b1;
    @(negedge clk);
    ctx_clr = '0;
    txn("t4a", 2'd2, 32'd500, 32'd500, 1'b0);
    txn("t4b", 2'd2, 32'd700, 32'd200, 1'b1);
    txn("t4c", 2'd2, 32'd30, 32'd30, 1'b0);

    // 5: reset during CALC aborts and wipes history
    req_data[1]  = 32'd50;
    req_valid[1] = 1'b1;
    wait_out("t5_dummy_wait");
    @(negedge clk);
    req_data[1]  = 32'd50;
    req_valid[1] = 1'b1;
    #1;
    chk("t5_grant", req_ready[1], 1);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_vld", out_valid, 0);
    chk("t5_data", out_data, 0);
    chk("t5_rdy", req_ready, 0);
    @(negedge clk);
    chk("t5_vld2", out_valid, 0);
    txn("t5a", 2'd1, 32'd7, 32'd7, 1'b0);
    txn("t5b", 2'd2, 32'd9, 32'd9, 1'b0);
    txn("t5c", 2'd0, 32'd15, 32'd15, 1'b0);

    // 6: two channels always valid
    do_reset();
    req_data[0] = 32'd5;
    req_data[1] = 32'd6;
    req_valid   = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      wait_out("t6_wait");
      chk("t6_ch", out_ch, t6_ch[k]);
      chk("t6_data", out_data, t6_d[k]);
      if (k == 5) req_valid = '0;
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
